// File: rtl/axis_latch_arbiter_if.sv
// Bundle of the requester streams and the latched output stream around
// axis_latch_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the requesters/consumer surrounding it.
interface axis_latch_arbiter_if #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int N_PORTS          = 4
);
  localparam int TID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [N_PORTS-1:0]                  s_axis_tvalid;
  logic [N_PORTS-1:0]                  s_axis_tready;
  logic [AXIS_TDATA_WIDTH-1:0]         m_axis_tdata;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic [TID_W-1:0]                    m_axis_tid;
  logic                                update;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, update
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid, update
  );
endinterface

// File: rtl/axis_latch_arbiter.sv
// Round-robin arbiter that latches one word from one of N_PORTS requesters
// into a constant output register. Each accepted word is followed by an
// optional hold-off of HOLD_CYCLES cycles before the next arbitration.
module axis_latch_arbiter #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int N_PORTS          = 4,
  parameter int HOLD_CYCLES      = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_latch_arbiter_if.slave   bus
);

  localparam int TID_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [TID_W-1:0]            grant_idx;
  logic [TID_W-1:0]            last_grant;
  logic [TID_W-1:0]            pick;
  logic                        any_req;
  logic                        fire;
  logic [7:0]                  hold_cnt;
  logic [N_PORTS-1:0]          ready;
  logic [AXIS_TDATA_WIDTH-1:0] req_data [N_PORTS];

  // The latched output never back-pressures, so its ready is not consulted.
  logic unused_m_tready;
  assign unused_m_tready = bus.m_axis_tready;

  // Unpack the requester data bus so the granted word is a plain array select.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign req_data[i] = bus.s_axis_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
  end

  assign any_req = |bus.s_axis_tvalid;
  assign fire    = (state == GRANT) && bus.s_axis_tvalid[grant_idx];

  // Round-robin pick: first requester scanning upward from last_grant+1, so
  // the most recent winner is considered last.
  always_comb begin
    logic found;
    int   idx_i;
    logic [TID_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx_i = 0;
    idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx_i = (int'(last_grant) + k) % N_PORTS;
      idx   = TID_W'(idx_i);
      if (!found && bus.s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a granted port that dropped tvalid simply loses its turn.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = GRANT;
      GRANT:   state_next = (fire && (HOLD_CYCLES > 0)) ? HOLD : IDLE;
      HOLD:    if (hold_cnt == 8'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is decoded from registered state only, keeping inputs off the ready path.
  always_comb begin
    ready = '0;
    if (state == GRANT) ready[grant_idx] = 1'b1;
  end

  assign bus.s_axis_tready = ready;

  // Grant capture, output latch, update pulse and hold-off counter.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      grant_idx         <= '0;
      last_grant        <= TID_W'(N_PORTS - 1);
      hold_cnt          <= 8'd0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tid    <= '0;
      bus.update        <= 1'b0;
    end else begin
      bus.update <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) grant_idx <= pick;
        end
        GRANT: begin
          if (fire) begin
            bus.m_axis_tdata  <= req_data[grant_idx];
            bus.m_axis_tid    <= grant_idx;
            bus.m_axis_tvalid <= 1'b1;
            bus.update        <= 1'b1;
            last_grant        <= grant_idx;
            if (HOLD_CYCLES > 0) hold_cnt <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_latch_arbiter.sv
// Directed bench for axis_latch_arbiter: one instance without hold-off and
// one with HOLD_CYCLES=3, driven from a single linear stimulus sequence.
module tb_axis_latch_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   cyc;

  axis_latch_arbiter_if #(.AXIS_TDATA_WIDTH(32), .N_PORTS(4)) b0 ();
  axis_latch_arbiter_if #(.AXIS_TDATA_WIDTH(32), .N_PORTS(4)) b3 ();

  axis_latch_arbiter #(.AXIS_TDATA_WIDTH(32), .N_PORTS(4), .HOLD_CYCLES(0)) dut0 (
    .aclk   (clk),
    .areset (rst),
    .bus    (b0)
  );

  axis_latch_arbiter #(.AXIS_TDATA_WIDTH(32), .N_PORTS(4), .HOLD_CYCLES(3)) dut3 (
    .aclk   (clk),
    .areset (rst),
    .bus    (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_g [5];
    n_cmp = 0;
    n_err = 0;
    exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd3; exp_g[4] = 2'd0;

    b0.s_axis_tdata = '0; b0.s_axis_tvalid = '0; b0.m_axis_tready = 1'b1;
    b3.s_axis_tdata = '0; b3.s_axis_tvalid = '0; b3.m_axis_tready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_tdata",  b0.m_axis_tdata, 0);
    chk("rst_tvalid", b0.m_axis_tvalid, 0);
    chk("rst_tid",    b0.m_axis_tid, 0);
    chk("rst_update", b0.update, 0);
    chk("rst_tready", b0.s_axis_tready, 0);
    chk("rst_tready3", b3.s_axis_tready, 0);

    // Single write from port 2: grant after one edge, latch after the second
    b0.s_axis_tdata[2*32 +: 32] = 32'hDEADBEEF;
    b0.s_axis_tvalid = 4'b0100;
    tick();
    chk("p2_tready",      b0.s_axis_tready, 4'b0100);
    chk("p2_pre_tvalid",  b0.m_axis_tvalid, 0);
    chk("p2_pre_update",  b0.update, 0);
    tick();
    chk("p2_tdata",  b0.m_axis_tdata, 32'hDEADBEEF);
    chk("p2_tid",    b0.m_axis_tid, 2);
    chk("p2_tvalid", b0.m_axis_tvalid, 1);
    chk("p2_update", b0.update, 1);
    chk("p2_tready_after", b0.s_axis_tready, 0);
    b0.s_axis_tvalid = '0;
    tick();
    chk("p2_update_pulse", b0.update, 0);
    chk("p2_tdata_hold",   b0.m_axis_tdata, 32'hDEADBEEF);

    // Four continuous requesters, output ready held low: 0,1,2,3,0 every 2 cycles
    do_reset();
    b0.m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) b0.s_axis_tdata[i*32 +: 32] = 32'hA0 + 32'(i);
    b0.s_axis_tvalid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_tready", b0.s_axis_tready, 4'b0001 << exp_g[k]);
      chk("rr_gap_update", b0.update, 0);
      tick();
      chk("rr_tid",    b0.m_axis_tid, exp_g[k]);
      chk("rr_tdata",  b0.m_axis_tdata, 32'hA0 + 32'(exp_g[k]));
      chk("rr_update", b0.update, 1);
      chk("rr_tvalid", b0.m_axis_tvalid, 1);
    end
    b0.s_axis_tvalid = '0;
    tick();
    chk("rr_tvalid_sticky", b0.m_axis_tvalid, 1);
    b0.m_axis_tready = 1'b1;

    // Hold-off of 3: ports 0 and 1, updates 5 cycles apart, no ready in hold
    b3.s_axis_tdata[0 +: 32]  = 32'h100;
    b3.s_axis_tdata[32 +: 32] = 32'h101;
    b3.s_axis_tvalid = 4'b0011;
    tick();
    chk("h3_tready0", b3.s_axis_tready, 4'b0001);
    tick();
    chk("h3_update0", b3.update, 1);
    chk("h3_tid0",    b3.m_axis_tid, 0);
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc < 4) chk("h3_hold_tready", b3.s_axis_tready, 0);
    end while (b3.update !== 1'b1 && cyc < 20);
    chk("h3_spacing1", cyc, 5);
    chk("h3_tid1",     b3.m_axis_tid, 1);
    chk("h3_tdata1",   b3.m_axis_tdata, 32'h101);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (b3.update !== 1'b1 && cyc < 20);
    chk("h3_spacing2", cyc, 5);
    chk("h3_tid2",     b3.m_axis_tid, 0);
    b3.s_axis_tvalid = '0;

    // Reset while port 1 is granted: no latch, outputs cleared, port 0 first after
    b0.s_axis_tdata[32 +: 32] = 32'h12345678;
    b0.s_axis_tdata[0 +: 32]  = 32'hAAA;
    b0.s_axis_tvalid = 4'b0010;
    tick();
    chk("rg_tready", b0.s_axis_tready, 4'b0010);
    rst = 1'b1;
    #1;
    chk("rg_async_tready", b0.s_axis_tready, 0);
    chk("rg_async_tdata",  b0.m_axis_tdata, 0);
    chk("rg_async_tvalid", b0.m_axis_tvalid, 0);
    tick();
    chk("rg_tdata",  b0.m_axis_tdata, 0);
    chk("rg_update", b0.update, 0);
    rst = 1'b0;
    b0.s_axis_tvalid = 4'b0011;
    tick();
    chk("rg_first_tready", b0.s_axis_tready, 4'b0001);
    tick();
    chk("rg_first_tid",   b0.m_axis_tid, 0);
    chk("rg_first_tdata", b0.m_axis_tdata, 32'hAAA);
    b0.s_axis_tvalid = '0;
    tick();

    // Granted port drops tvalid: no latch, back to idle, re-arbitrate from port 0
    b0.s_axis_tdata[2*32 +: 32] = 32'h55;
    b0.s_axis_tvalid = 4'b0100;
    tick();
    chk("dv_tready", b0.s_axis_tready, 4'b0100);
    b0.s_axis_tvalid = '0;
    tick();
    chk("dv_update", b0.update, 0);
    chk("dv_tdata",  b0.m_axis_tdata, 32'hAAA);
    chk("dv_tid",    b0.m_axis_tid, 0);
    chk("dv_tready_idle", b0.s_axis_tready, 0);
    b0.s_axis_tvalid = 4'b0110;
    tick();
    chk("dv_regrant", b0.s_axis_tready, 4'b0010);
    tick();
    chk("dv_tid1", b0.m_axis_tid, 1);
    b0.s_axis_tvalid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_latch_arbiter.md
AXIS_LATCH_ARBITER -- requirements
Module: axis_latch_arbiter

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, data width of every stream.
REQ-002 SHALL have parameter N_PORTS, default 4, number of slave requesters; legal range 2..8.
REQ-003 SHALL have parameter HOLD_CYCLES, default 0, hold-off cycles after each update; legal range 0..255.
REQ-004 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port areset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port s_axis_tdata  input  N_PORTS*AXIS_TDATA_WIDTH  packed requester data; port i at bits [i*W +: W].
REQ-007 SHALL have port s_axis_tvalid  input  N_PORTS  per-requester valid.
REQ-008 SHALL have port s_axis_tready  output  N_PORTS  per-requester ready, at most one bit set.
REQ-009 SHALL have port m_axis_tdata  output  AXIS_TDATA_WIDTH  latched constant.
REQ-010 SHALL have port m_axis_tvalid  output  1  high once any value has been latched.
REQ-011 SHALL have port m_axis_tready  input  1  ignored; latched output never back-pressures.
REQ-012 SHALL have port m_axis_tid  output  clog2(N_PORTS)  index of requester that wrote m_axis_tdata.
REQ-013 SHALL have port update  output  1  one-cycle pulse on cycle after each new latch.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, GRANT, HOLD.
REQ-015 IDLE: when any s_axis_tvalid bit high, SHALL register grant index = first requesting port found scanning upward from (last_grant+1) mod N_PORTS, wrapping, and enter GRANT.
REQ-016 IDLE with no requests SHALL remain IDLE; s_axis_tready all zero.
REQ-017 GRANT: s_axis_tready SHALL be one-hot at the registered grant index, combinationally from state only (no input-to-ready path).
REQ-018 GRANT: on s_axis_tvalid[g] & s_axis_tready[g], SHALL latch s_axis_tdata[g] into m_axis_tdata, g into m_axis_tid, set m_axis_tvalid, set last_grant=g, pulse update next cycle.
REQ-019 After a transfer, SHALL enter HOLD if HOLD_CYCLES>0 (counter loaded HOLD_CYCLES-1), else IDLE.
REQ-020 GRANT with granted tvalid low (protocol violation) SHALL return to IDLE without latching, last_grant unchanged.
REQ-021 HOLD: s_axis_tready all zero; counter decrements each cycle; at zero SHALL enter IDLE.
REQ-022 Throughput SHALL be one update per 2+HOLD_CYCLES cycles under continuous requests.
REQ-023 Latency from first tvalid in IDLE to m_axis_tdata change SHALL be 2 clock edges.
REQ-024 m_axis_tvalid SHALL stay high after first latch until reset; m_axis_tready has no effect.
REQ-025 Non-granted requesters SHALL keep tvalid asserted without loss; round-robin SHALL guarantee each requester a grant within N_PORTS arbitration rounds.
REQ-026 A requester whose tvalid is held continuously SHALL NOT be granted twice in a row while another port requests.

Reset
REQ-027 areset high SHALL asynchronously force: state IDLE, m_axis_tdata 0, m_axis_tvalid 0, m_axis_tid 0, update 0, s_axis_tready 0, hold counter 0, last_grant N_PORTS-1 (so port 0 wins first).
REQ-028 Reset asserted mid-GRANT or mid-HOLD SHALL abort without latching; release SHALL resume in IDLE on next rising edge.

Verification
REQ-029 Reset then port 2 writes 0xDEADBEEF -> tready[2] high one cycle, m_axis_tdata=0xDEADBEEF, m_axis_tid=2, m_axis_tvalid=1, update pulse, 2 edges after tvalid.
REQ-030 All 4 ports valid continuously, HOLD_CYCLES=0 -> grants 0,1,2,3,0 in order, one update every 2 cycles.
REQ-031 HOLD_CYCLES=3, ports 0 and 1 requesting -> updates exactly 5 cycles apart, tready all zero during HOLD.
REQ-032 m_axis_tready held 0 throughout REQ-030 -> identical behaviour; m_axis_tvalid never drops.
REQ-033 areset pulsed while in GRANT for port 1 with data 0x12345678 -> no latch, outputs zero, port 0 granted first after release.
REQ-034 Granted port drops tvalid in GRANT -> no update, FSM IDLE, next grant re-arbitrates from unchanged last_grant.
